tt_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a combinational N-input, 1-output logic block in hardware. On `start` it drives every input vector 0..2^N-1 in ascending order, waits a programmable settle time, samples the block's output, assembles the captured truth table and compares it against a latched expected table. It sits between a small-function datapath (e.g. a 4-input SOP/POS gate network with inputs a,b,c,d and output s) and the lab's status/LED logic, replacing manual input sweeps with a single self-checking run.

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_settle_timer.sv | 33 +++
 rtl/tt_sweep_ctrl.sv | 126 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep controller.
package tt_sweep_pkg;

  // Default geometry: a 4-input block held one cycle before each sample.
  localparam int N_IN_DEFAULT   = 4;
  localparam int SETTLE_DEFAULT = 1;

  // Sequencer states: wait for start, hold a vector, capture it, report.
  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweep_state_t;

  // Width of a counter that must reach settle-1; never narrower than one bit.
  function automatic int timer_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: cleared when a new vector goes out, counts while the
// vector is held, and flags when the hold has lasted SETTLE cycles.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = timer_width(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // Count up while holding; park on the last value so expired stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector of a small
// combinational block in ascending order, captures its output and compares
// the result against an expected table latched at start.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   captured,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err,
  output logic                 pass
);

  localparam int              DEPTH    = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  sweep_state_t      state;
  logic [DEPTH-1:0]  expected_q;
  logic [N_IN-1:0]   idx;
  logic              timer_clear;
  logic              timer_enable;
  logic              settle_expired;
  logic              sample_miss;
  logic [N_IN:0]     mismatch_next;

  // The vector index is itself a register, so the driven vector is glitch-free.
  assign dut_in = idx;

  // Restart the hold timer whenever a new vector is about to be driven.
  assign timer_clear  = ((state == IDLE) && start) || (state == SAMPLE);
  assign timer_enable = (state == DRIVE);

  // Compare the block's output against the latched table for this vector;
  // the incremented count is needed so pass can include the final sample.
  assign sample_miss   = (dut_out != expected_q[idx]);
  assign mismatch_next = mismatch_cnt + (N_IN+1)'(sample_miss);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (settle_expired)
  );

  // Sweep sequencer with compare/accumulate; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      expected_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      captured     <= '0;
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      first_err    <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expected_q   <= expected;
            captured     <= '0;
            mismatch_cnt <= '0;
            err_valid    <= 1'b0;
            first_err    <= '0;
            pass         <= 1'b0;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= DRIVE;
          end
        end

        DRIVE: begin
          if (settle_expired) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          captured[idx] <= dut_out;
          if (sample_miss) begin
            mismatch_cnt <= mismatch_next;
            if (!err_valid) begin
              first_err <= idx;
              err_valid <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            pass  <= (mismatch_next == '0);
            state <= DONE;
          end else begin
            idx   <= idx + N_IN'(1);
            state <= DRIVE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// sweep a small gate network; results are checked against a table-level model.
module tb_tt_sweep_ctrl;

  localparam logic [15:0] TT_REF = 16'hAC3C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected_in;
  int          sel;
  int          checks;
  int          errors;

  logic        start_a, start_b;
  logic [3:0]  dut_in_a, dut_in_b;
  logic        dut_out_a, dut_out_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] captured_a, captured_b;
  logic [4:0]  mismatch_a, mismatch_b;
  logic        err_valid_a, err_valid_b;
  logic [3:0]  first_err_a, first_err_b;
  logic        pass_a, pass_b;

  logic [3:0]  obs_dut_in;
  logic        obs_busy, obs_done, obs_err_valid, obs_pass;
  logic [15:0] obs_captured;
  logic [4:0]  obs_mismatch;
  logic [3:0]  obs_first_err;

  always #5 clk = ~clk;

  // Gate network under test: s = (b|c)&(a|~b|~c)&(~a|~b|d), inputs {a,b,c,d}.
  function automatic logic gate_net(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (b | c) & (a | ~b | ~c) & (~a | ~b | d);
  endfunction

  assign dut_out_a = gate_net(dut_in_a);
  assign dut_out_b = gate_net(dut_in_b);
  assign start_a   = start && (sel == 0);
  assign start_b   = start && (sel == 1);

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut_a (
    .clk (clk), .rst (rst), .start (start_a), .expected (expected_in),
    .dut_in (dut_in_a), .dut_out (dut_out_a), .busy (busy_a), .done (done_a),
    .captured (captured_a), .mismatch_cnt (mismatch_a), .err_valid (err_valid_a),
    .first_err (first_err_a), .pass (pass_a)
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut_b (
    .clk (clk), .rst (rst), .start (start_b), .expected (expected_in),
    .dut_in (dut_in_b), .dut_out (dut_out_b), .busy (busy_b), .done (done_b),
    .captured (captured_b), .mismatch_cnt (mismatch_b), .err_valid (err_valid_b),
    .first_err (first_err_b), .pass (pass_b)
  );

  // Route the selected instance's outputs to a common set of observation wires.
  always_comb begin
    obs_dut_in    = dut_in_a;
    obs_busy      = busy_a;
    obs_done      = done_a;
    obs_captured  = captured_a;
    obs_mismatch  = mismatch_a;
    obs_err_valid = err_valid_a;
    obs_first_err = first_err_a;
    obs_pass      = pass_a;
    if (sel == 1) begin
      obs_dut_in    = dut_in_b;
      obs_busy      = busy_b;
      obs_done      = done_b;
      obs_captured  = captured_b;
      obs_mismatch  = mismatch_b;
      obs_err_valid = err_valid_b;
      obs_first_err = first_err_b;
      obs_pass      = pass_b;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (sel=%0d, t=%0t)", tag, got, want, sel, $time);
    end
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_dut_in"},    32'(obs_dut_in), 0);
    checkOutput({phase, "_busy"},      32'(obs_busy), 0);
    checkOutput({phase, "_done"},      32'(obs_done), 0);
    checkOutput({phase, "_captured"},  32'(obs_captured), 0);
    checkOutput({phase, "_mismatch"},  32'(obs_mismatch), 0);
    checkOutput({phase, "_err_valid"}, 32'(obs_err_valid), 0);
    checkOutput({phase, "_first_err"}, 32'(obs_first_err), 0);
    checkOutput({phase, "_pass"},      32'(obs_pass), 0);
  endtask

  // One sweep on instance 'which'. disturb_at: cycle to re-pulse start and
  // change expected; rst_at: cycle to abort with reset (-1 disables either).
  task automatic applyStimulus(input int which, input logic [15:0] exp_tt,
                               input int disturb_at, input int rst_at);
    int          period, m, done_at, done_cnt, seq_bad, exp_miss, exp_first;
    logic [15:0] diff;
    logic        busy_at_done;
    logic        aborted;

    period    = (which == 1) ? 4 : 2;
    diff      = exp_tt ^ TT_REF;
    exp_miss  = 0;
    exp_first = 0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin
        exp_miss++;
        exp_first = i;
      end
    end

    sel = which;
    @(negedge clk);
    expected_in = exp_tt;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    m            = 0;
    done_at      = -1;
    done_cnt     = 0;
    seq_bad      = 0;
    busy_at_done = 1'b0;
    aborted      = 1'b0;
    checkOutput("busy_after_start", 32'(obs_busy), 1);

    while (m < 16 * period + 10) begin
      if (obs_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = m;
          busy_at_done = obs_busy;
        end
      end
      if (m < 16 * period && obs_dut_in != 4'(m / period)) seq_bad++;
      if (m == disturb_at) begin
        start       = 1'b1;
        expected_in = ~exp_tt;
      end else begin
        start = 1'b0;
      end
      if (m == rst_at) begin
        rst = 1'b1;
        #1;
        checkResetState("abort");
        checkOutput("abort_no_done", 32'(done_cnt), 0);
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done_at >= 0 && m == done_at + 3) break;
      @(posedge clk);
      #1;
      m++;
    end
    start = 1'b0;

    if (!aborted) begin
      checkOutput("done_latency", 32'(done_at), 32'(16 * period));
      checkOutput("done_pulses",  32'(done_cnt), 1);
      checkOutput("busy_at_done", 32'(busy_at_done), 1);
      checkOutput("busy_after",   32'(obs_busy), 0);
      checkOutput("dut_in_seq",   32'(seq_bad), 0);
      checkOutput("captured",     32'(obs_captured), 32'(TT_REF));
      checkOutput("mismatch_cnt", 32'(obs_mismatch), 32'(exp_miss));
      checkOutput("err_valid",    32'(obs_err_valid), 32'(exp_miss != 0));
      if (exp_miss != 0) checkOutput("first_err", 32'(obs_first_err), 32'(exp_first));
      checkOutput("pass_held",    32'(obs_pass), 32'(exp_miss == 0));
    end
  endtask

  initial begin
    logic [15:0] mask;
    rst         = 1'b1;
    start       = 1'b0;
    expected_in = '0;
    sel         = 0;
    checks      = 0;
    errors      = 0;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("por");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 16'hAC3C, -1, -1);
    applyStimulus(0, 16'hAC3D, -1, -1);
    applyStimulus(0, 16'h53C3, -1, -1);
    applyStimulus(0, 16'hAC3E, -1, -1);
    applyStimulus(0, 16'h0F0F, 10, -1);
    applyStimulus(0, 16'hAC3C, -1, 12);
    applyStimulus(0, 16'hAC3C, -1, -1);
    applyStimulus(1, 16'hAC3C, -1, -1);
    applyStimulus(1, 16'h2C3C, -1, -1);

    for (int r = 0; r < 8; r++) begin
      mask = 16'($urandom) & 16'($urandom);
      applyStimulus(int'($urandom_range(0, 1)), TT_REF ^ mask, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
